mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter TIMEOUT, default 16, maximum BUSY cycles before a transaction is aborted; legal range 2..255.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_req  input  1  instruction-fetch request, held until i_ack.
REQ-006 i_addr  input  WIDTH  fetch address, stable while i_req is high.
REQ-007 i_rdata  output  WIDTH  fetch data, valid when i_ack is high.
REQ-008 i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request, held until d_ack.
REQ-010 d_we  input  1  data request is a write (1) or a read (0).
REQ-011 d_addr, d_wdata  input  WIDTH each  data address and write data, stable while d_req is high.
REQ-012 d_rdata  output  WIDTH  load data, valid when d_ack is high.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 stall_F, stall_M  output  1 each  stall_F = i_req & ~i_ack; stall_M = d_req & ~d_ack.
REQ-015 m_req, m_we  output  1 each  shared memory request and write enable, registered.
REQ-016 m_addr, m_wdata  output  WIDTH each  registered copies of the granted request's address and write data.
REQ-017 m_rdata  input  WIDTH  memory read data, valid with m_ack.
REQ-018 m_ack  input  1  one-cycle memory completion pulse.
REQ-019 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-020 The FSM shall have states IDLE, BUSY_I and BUSY_D.
REQ-021 In IDLE with any request pending, the FSM shall enter BUSY_I or BUSY_D at the next edge and latch the winner's address, write data and d_we into the m_* registers, with m_req=1.
REQ-022 IDLE with no request shall hold IDLE, with m_req=0 and m_we=0.
REQ-023 In BUSY_x, m_ack=1 shall pass m_rdata combinationally to x_rdata and pulse x_ack in the same cycle; at the next edge m_req drops and the FSM returns to IDLE.
REQ-024 Minimum latency from request to ack shall be 1 cycle (request seen in cycle 0, ack in cycle 1 when memory acks immediately); back-to-back grants shall have one IDLE cycle between them.
REQ-025 For a write grant, m_we=1, and d_rdata shall be don't-care at d_ack.
REQ-026 A 8-bit counter shall clear on entering BUSY and increment each BUSY cycle without m_ack.
REQ-027 If the counter reaches TIMEOUT-1 without m_ack, the block shall pulse err, pulse x_ack with x_rdata=0, drop m_req and return to IDLE.
REQ-028 If m_ack and timeout occur in the same cycle, m_ack shall win: normal completion, no err.
REQ-029 m_ack received in IDLE shall be ignored.
REQ-030 Requests arriving during BUSY shall wait; the ungranted requester's stall output stays high.
REQ-031 i_ack and d_ack shall never both be high in the same cycle.

Reset
REQ-032 With rst=0 at a rising edge: state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, counter=0, err=0, last_grant=instruction.
REQ-033 Reset during BUSY shall abandon the transaction with no ack and no err; requesters re-arbitrate after reset.
REQ-034 While rst=0, i_ack, d_ack and err shall be 0.

Configuration
REQ-035 With ARB_RR_EN defined, simultaneous i_req and d_req in IDLE shall be granted to the requester that did not win the last grant; last_grant updates on every grant.
REQ-036 Without ARB_RR_EN, simultaneous requests shall always be granted to the data port, and last_grant is not implemented.

Verification
REQ-037 Fetch of 0x100, memory acks 1 cycle after m_req with 0xDEADBEEF -> m_req in cycle 1, i_ack and i_rdata=0xDEADBEEF in cycle 2, IDLE in cycle 3.
REQ-038 i_req and d_req together, no ARB_RR_EN -> data granted first, fetch granted in the cycle after d_ack+1, stall_F high throughout.
REQ-039 ARB_RR_EN, both requesters continuously pending for 4 grants -> grant order D, I, D, I.
REQ-040 TIMEOUT=16, memory never acks -> err and d_ack pulse together 15 cycles after m_req rises, d_rdata=0, m_req=0 next cycle.
REQ-041 m_ack in the exact timeout cycle -> normal ack with memory data, err stays 0.
REQ-042 rst driven low mid-BUSY -> next edge m_req=0, state IDLE, no ack or err pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single shared memory interface. One transaction is outstanding at a time.
// The bus request is held until the memory acks or a busy-cycle timeout
// aborts it.
//
// Parameters:
//   WIDTH   - data/address width
//   TIMEOUT - busy cycles allowed before abort (2..255)
//
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   i_req/i_addr             - fetch request and address
//   i_rdata/i_ack            - fetch data and completion pulse
//   d_req/d_we/d_addr/d_wdata- data request, direction, address and write data
//   d_rdata/d_ack            - load data and completion pulse
//   stall_F/stall_M          - requester stalls (request pending, not acked)
//   m_req/m_we/m_addr/m_wdata- registered shared memory request
//   m_rdata/m_ack            - memory read data and completion pulse
//   err                      - pulse on timeout abort
//
// Build option: define ARB_RR_EN to alternate grants between simultaneous
// requesters. Without it, simultaneous requests always go to the data port.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_ack,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_ack,
  output logic             stall_F,
  output logic             stall_M,
  output logic             m_req,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  input  logic [WIDTH-1:0] m_rdata,
  input  logic             m_ack,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             busy, timeout, done, grant_d;

`ifdef ARB_RR_EN
  // 1 when the data port won the most recent grant
  logic last_d_q, last_d_d;
  assign grant_d = d_req & (~i_req | ~last_d_q);
`else
  assign grant_d = d_req;
`endif

  assign busy    = (state_q != IDLE);
  // m_ack takes priority over a timeout landing in the same cycle
  assign timeout = busy & ~m_ack & (cnt_q == CNT_LAST);
  assign done    = rst & busy & (m_ack | timeout);

  assign i_ack   = done & (state_q == BUSY_I);
  assign d_ack   = done & (state_q == BUSY_D);
  assign i_rdata = (i_ack & m_ack) ? m_rdata : '0;
  assign d_rdata = (d_ack & m_ack) ? m_rdata : '0;
  assign err     = rst & timeout;
  assign stall_F = i_req & ~i_ack;
  assign stall_M = d_req & ~d_ack;

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    cnt_d     = cnt_q;
`ifdef ARB_RR_EN
    last_d_d  = last_d_q;
`endif
    unique case (state_q)
      IDLE: begin
        m_req_d = 1'b0;
        m_we_d  = 1'b0;
        if (i_req | d_req) begin
          m_req_d = 1'b1;
          cnt_d   = '0;
          if (grant_d) begin
            state_d   = BUSY_D;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
          end else begin
            state_d  = BUSY_I;
            m_addr_d = i_addr;
          end
`ifdef ARB_RR_EN
          last_d_d = grant_d;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (m_ack | timeout) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      cnt_q     <= '0;
`ifdef ARB_RR_EN
      last_d_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      cnt_q     <= cnt_d;
`ifdef ARB_RR_EN
      last_d_q  <= last_d_d;
`endif
    end
  end

endmodule
